// File: rtl/router_1xn.sv
// router_1xn: one input packet stream routed to NUM_PORTS port FIFOs, with parity check and read timeout.
// Optional per-port good-packet counters on pkt_cnt when ROUTER_PKT_CNT_EN is defined.
module router_1xn #(
    parameter int NUM_PORTS  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 30
) (
    input  logic                            clock,
    input  logic                            resetn,
    input  logic                            pkt_valid,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [NUM_PORTS-1:0]            read_enb,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic [NUM_PORTS-1:0]            vld_out,
    output logic [NUM_PORTS-1:0]            soft_reset,
    output logic                            busy,
    output logic                            error,
    output logic                            drop
`ifdef ROUTER_PKT_CNT_EN
    ,
    output logic [NUM_PORTS*16-1:0]         pkt_cnt
`endif
);
    localparam int ADDR_W = $clog2(NUM_PORTS);
    localparam int LEN_W  = DATA_WIDTH - ADDR_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam int NPAD   = 1 << ADDR_W;
    localparam logic [LEN_W:0] CNT_ONE = (LEN_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     dest;
    logic [LEN_W:0]        cnt;
    logic [DATA_WIDTH-1:0] acc;

    logic [DATA_WIDTH-1:0] mem     [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr  [NUM_PORTS];
    logic [PTR_W:0]        rd_ptr  [NUM_PORTS];
    logic [PTR_W-1:0]      wr_addr [NUM_PORTS];
    logic [TMR_W-1:0]      timer   [NUM_PORTS];
    logic [DATA_WIDTH-1:0] dout    [NUM_PORTS];

    logic [NUM_PORTS-1:0]  full, empty, flush, wr_en, rd_en;
    logic [NPAD-1:0]       full_pad, flush_pad;
    logic [ADDR_W-1:0]     hdr_addr;
    logic [LEN_W-1:0]      hdr_len;
    logic                  addr_ok, accept;

    assign hdr_addr = data_in[ADDR_W-1:0];
    assign hdr_len  = data_in[DATA_WIDTH-1:ADDR_W];
    assign addr_ok  = {1'b0, hdr_addr} < (ADDR_W + 1)'(NUM_PORTS);

    always_comb begin
        full_pad  = '0;
        flush_pad = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][PTR_W] != rd_ptr[i][PTR_W]) &&
                       (wr_ptr[i][PTR_W-1:0] == rd_ptr[i][PTR_W-1:0]);
            flush[i] = ~empty[i] & ~read_enb[i] & (timer[i] == TMR_W'(TIMEOUT - 1));
            rd_en[i] = read_enb[i] & ~empty[i];
        end
        full_pad[NUM_PORTS-1:0]  = full;
        flush_pad[NUM_PORTS-1:0] = flush;
    end

    always_comb begin
        busy = 1'b0;
        case (state)
            IDLE:            busy = pkt_valid & addr_ok & full_pad[hdr_addr];
            PAYLOAD, PARITY: busy = full_pad[dest];
            default:         busy = 1'b0;
        endcase
    end

    assign accept = pkt_valid & ~busy;

    // A header may land in a FIFO being flushed this cycle; payload words to a flushed dest are discarded.
    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (state == IDLE)
                wr_en[i] = accept & addr_ok & (hdr_addr == ADDR_W'(i));
            else if (state == PAYLOAD || state == PARITY)
                wr_en[i] = accept & (dest == ADDR_W'(i)) & ~flush[i];
            wr_addr[i] = flush[i] ? PTR_W'(0) : wr_ptr[i][PTR_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            dest  <= '0;
            cnt   <= '0;
            acc   <= '0;
            error <= 1'b0;
            drop  <= 1'b0;
        end else begin
            drop <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    if (addr_ok) begin
                        dest  <= hdr_addr;
                        acc   <= data_in;
                        error <= 1'b0;
                        cnt   <= {1'b0, hdr_len};
                        state <= (hdr_len == '0) ? PARITY : PAYLOAD;
                    end else begin
                        drop  <= 1'b1;
                        cnt   <= {1'b0, hdr_len} + 1'b1;
                        state <= DROP;
                    end
                end
                PAYLOAD: if (flush_pad[dest]) begin
                    // cnt becomes the words still to discard, parity included
                    cnt   <= accept ? cnt : cnt + 1'b1;
                    state <= DROP;
                end else if (accept) begin
                    acc <= acc ^ data_in;
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_ONE) state <= PARITY;
                end
                PARITY: if (flush_pad[dest]) begin
                    cnt   <= CNT_ONE;
                    state <= accept ? IDLE : DROP;
                end else if (accept) begin
                    error <= (data_in != acc);
                    state <= IDLE;
                end
                DROP: if (accept) begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_ONE) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                wr_ptr[i]     <= '0;
                rd_ptr[i]     <= '0;
                timer[i]      <= '0;
                dout[i]       <= '0;
                soft_reset[i] <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                soft_reset[i] <= flush[i];
                if (flush[i]) begin
                    rd_ptr[i] <= '0;
                    wr_ptr[i] <= wr_en[i] ? (PTR_W + 1)'(1) : '0;
                    dout[i]   <= '0;
                    timer[i]  <= '0;
                end else begin
                    if (wr_en[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    if (rd_en[i]) begin
                        dout[i]   <= mem[i][rd_ptr[i][PTR_W-1:0]];
                        rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    end
                    timer[i] <= (empty[i] | read_enb[i]) ? '0 : timer[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++)
            if (wr_en[i]) mem[i][wr_addr[i]] <= data_in;
    end

    always_comb begin
        data_out = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            data_out[i*DATA_WIDTH +: DATA_WIDTH] = dout[i];
            vld_out[i] = ~empty[i];
        end
    end

`ifdef ROUTER_PKT_CNT_EN
    logic [15:0] pcnt [NUM_PORTS];
    logic        good_parity;

    assign good_parity = (state == PARITY) & accept & ~flush_pad[dest] & (data_in == acc);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) pcnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++)
                if (good_parity && dest == ADDR_W'(i)) pcnt[i] <= pcnt[i] + 1'b1;
        end
    end

    always_comb begin
        pkt_cnt = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) pkt_cnt[i*16 +: 16] = pcnt[i];
    end
`endif
endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: randomized and directed stimulus against a queue-based packet model with a read-side scoreboard.
// Builds with or without ROUTER_PKT_CNT_EN.
module tb_router_1xn;
    localparam int NP    = 3;
    localparam int DW    = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 16;
    localparam int TMO   = 30;

    logic              clock = 1'b0;
    logic              resetn;
    logic              pkt_valid = 1'b0;
    logic [DW-1:0]     data_in = '0;
    logic [NP-1:0]     read_enb = '0;
    logic [NP*DW-1:0]  data_out;
    logic [NP-1:0]     vld_out, soft_reset;
    logic              busy, error, drop;
`ifdef ROUTER_PKT_CNT_EN
    logic [NP*16-1:0]  pkt_cnt;
`endif

    router_1xn #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .read_enb(read_enb), .data_out(data_out), .vld_out(vld_out),
        .soft_reset(soft_reset), .busy(busy), .error(error), .drop(drop)
`ifdef ROUTER_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    always #5 clock = ~clock;

    int cmp_n = 0;
    int err_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: port FIFOs as queues, packet progress as words-left count.
    logic [DW-1:0] q [NP][$];
    int            unread [NP];
    int            good_cnt [NP];
    int            m_left, m_dest, m_len, m_addr;
    bit            m_routed, m_busy, m_accept, exp_err, exp_drop;
    logic [DW-1:0] m_par;
    logic [NP-1:0] exp_soft, m_fl, rd_pending;

    always @(negedge clock) begin
        #3;
        if (!resetn) begin
            chk("rst_busy", busy, 0);
            chk("rst_vld", vld_out, 0);
            chk("rst_error", error, 0);
            chk("rst_drop", drop, 0);
            chk("rst_soft", soft_reset, 0);
            chk("rst_dout", data_out, 0);
            for (int i = 0; i < NP; i++) begin
                q[i].delete();
                unread[i] = 0;
                good_cnt[i] = 0;
            end
            m_left = 0; m_routed = 0; m_accept = 0;
            exp_err = 0; exp_drop = 0; exp_soft = '0; rd_pending = '0;
        end else begin
            chk("error", error, exp_err);
            chk("drop", drop, exp_drop);
            chk("soft_reset", soft_reset, exp_soft);
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("vld_out%0d", i), vld_out[i], q[i].size() != 0);
                if (exp_soft[i]) chk($sformatf("flush_dout%0d", i), data_out[i*DW +: DW], 0);
            end
            m_addr = int'(data_in[AW-1:0]);
            if (m_left == 0)
                m_busy = pkt_valid && m_addr < NP && q[m_addr].size() == DEPTH;
            else if (m_routed)
                m_busy = q[m_dest].size() == DEPTH;
            else
                m_busy = 0;
            chk("busy", busy, m_busy);
            m_accept = pkt_valid && !m_busy;

            m_fl = '0;
            for (int i = 0; i < NP; i++) begin
                rd_pending[i] = read_enb[i] && q[i].size() != 0;
                if (q[i].size() != 0 && !read_enb[i]) begin
                    unread[i]++;
                    if (unread[i] == TMO) begin
                        m_fl[i] = 1'b1;
                        unread[i] = 0;
                        q[i].delete();
                    end
                end else begin
                    unread[i] = 0;
                end
            end
            exp_soft = m_fl;
            exp_drop = 0;

            if (m_left > 0 && m_routed && m_fl[m_dest]) begin
                m_routed = 0;
                if (m_accept) m_left--;
            end else if (m_accept) begin
                if (m_left == 0) begin
                    m_len  = int'(data_in[DW-1:AW]);
                    m_left = m_len + 1;
                    if (m_addr < NP) begin
                        m_routed = 1; m_dest = m_addr; m_par = data_in; exp_err = 0;
                        q[m_addr].push_back(data_in);
                    end else begin
                        m_routed = 0; exp_drop = 1;
                    end
                end else if (m_routed) begin
                    q[m_dest].push_back(data_in);
                    if (m_left == 1) begin
                        exp_err = (data_in != m_par);
                        if (data_in == m_par) good_cnt[m_dest]++;
                    end else begin
                        m_par = m_par ^ data_in;
                    end
                    m_left--;
                end else begin
                    m_left--;
                end
            end
        end
    end

    // Scoreboard: every read accepted last cycle must present the oldest queued word.
    logic [DW-1:0] sb_exp;
    always @(posedge clock) begin
        #1;
        for (int i = 0; i < NP; i++) begin
            if (rd_pending[i]) begin
                rd_pending[i] = 1'b0;
                if (q[i].size() == 0) begin
                    chk($sformatf("sb_underflow%0d", i), 1, 0);
                end else begin
                    sb_exp = q[i].pop_front();
                    chk($sformatf("data_out%0d", i), data_out[i*DW +: DW], sb_exp);
                end
            end
        end
    end

    // Stimulus
    int rd_pct [NP];
    int rd_once_port = -1;
    int rd_once_delay = 0;

    task automatic set_rd(input int a, input int b, input int c);
        rd_pct[0] = a; rd_pct[1] = b; rd_pct[2] = c;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] w);
        logic [NP-1:0] r;
        @(negedge clock);
        r = '0;
        for (int i = 0; i < NP; i++) if ($urandom_range(99) < rd_pct[i]) r[i] = 1'b1;
        if (rd_once_port >= 0) begin
            if (rd_once_delay == 0) begin
                r[rd_once_port] = 1'b1;
                rd_once_port = -1;
            end else begin
                rd_once_delay--;
            end
        end
        pkt_valid = v; data_in = w; read_enb = r;
        #4;
    endtask

    task automatic send(input logic [DW-1:0] w);
        int n = 0;
        do begin
            drive(1'b1, w);
            n++;
        end while (!m_accept && n < 400);
        if (!m_accept) begin
            cmp_n++; err_n++;
            $display("FAIL send_timeout @%0t: word %0h not accepted within %0d cycles", $time, w, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, DW'($urandom));
    endtask

    task automatic drain();
        set_rd(100, 100, 100);
        idle(24);
        set_rd(0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        resetn = 1'b0; pkt_valid = 1'b0; read_enb = '0;
        repeat (n) @(negedge clock);
        resetn = 1'b1;
        #4;
    endtask

    logic [DW-1:0] tx_par, w, hdr;
    int a, len, n;

    initial begin
        resetn = 1'b1;
        set_rd(0, 0, 0);
        #1 resetn = 1'b0;
        repeat (3) @(negedge clock);
        resetn = 1'b1;

        // good packet to port 1
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        idle(2);
        chk("tp1_vld", vld_out, 3'b010);
        chk("tp1_error", error, 0);
        drain();

        // bad parity
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
        idle(1);
        chk("tp2_error", error, 1);
        drain();

        // invalid address dropped, then port 0
        send(8'h0B); send(8'hA1); send(8'hA2); send(8'hA3);
        send(8'h04); send(8'h55);
        chk("tp2_error_clear", error, 0);
        send(8'h51);
        drain();

        // backpressure on port 0
        send(8'h50);
        tx_par = 8'h50;
        for (int j = 0; j < 20; j++) begin
            w = DW'($urandom);
            tx_par = tx_par ^ w;
            if (j == 15) begin rd_once_port = 0; rd_once_delay = 4; end
            if (j == 16) begin rd_once_port = 0; rd_once_delay = 3; end
            if (j == 17) set_rd(50, 0, 0);
            send(w);
        end
        send(tx_par);
        drain();

        // timeout flush on port 2
        send(8'h06);
        rd_once_port = 2; rd_once_delay = 0;
        send(8'hA5); send(8'hA3);
        n = 0;
        do begin
            idle(1);
            n++;
        end while (!soft_reset[2] && n < 45);
        chk("tp5_soft_seen", soft_reset[2], 1);
        chk("tp5_vld", vld_out[2], 0);
        chk("tp5_dout", data_out[2*DW +: DW], 0);
        drain();

        // reset mid-payload
        send(8'h0D); send(8'h11); send(8'h22);
        do_reset(2);
        chk("tp6_vld", vld_out, 0);
        send(8'h0D); send(8'h11); send(8'h22); send(8'h33); send(8'h0D);
        drain();

        // random traffic
        for (int p = 0; p < 40; p++) begin
            case (p / 10)
                0: set_rd(60, 60, 60);
                1: set_rd(20, 50, 5);
                2: set_rd(0, 0, 0);
                default: set_rd(90, 90, 90);
            endcase
            a   = $urandom_range(3);
            len = (p % 8 == 0) ? $urandom_range(30) : $urandom_range(6);
            hdr = DW'((len << AW) | a);
            tx_par = hdr;
            send(hdr);
            for (int j = 0; j < len; j++) begin
                w = DW'($urandom);
                tx_par = tx_par ^ w;
                send(w);
                if ($urandom_range(3) == 0) idle(1);
            end
            send(($urandom_range(3) == 0) ? (tx_par ^ DW'($urandom_range(1, 255))) : tx_par);
            if ($urandom_range(4) == 0) idle($urandom_range(1, 40));
        end
        drain();

`ifdef ROUTER_PKT_CNT_EN
        for (int i = 0; i < NP; i++)
            chk($sformatf("pkt_cnt%0d", i), pkt_cnt[i*16 +: 16], good_cnt[i] & 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/router_1xn.md
Name: router_1xn

Overview:
- Parametrised successor of the 1x3 packet router: one input stream, NUM_PORTS output ports, each with a private FIFO.
- Packet framing: header word (destination address + payload length), then payload words, then a parity word.
- The block routes the packet to the addressed port FIFO and drops packets with an invalid address.
- It applies backpressure through busy, checks parity and flushes ports that are not read within a timeout.

Parameters:
- NUM_PORTS, 3, number of output ports (2..8)
- DATA_WIDTH, 8, word width (>= ADDR_W+2)
- FIFO_DEPTH, 16, entries per port FIFO (power of 2, >= 4)
- TIMEOUT, 30, consecutive unread cycles with vld_out high before soft reset
- ADDR_W, $clog2(NUM_PORTS), address field width (derived; not overridden)

Ports:
- clock  in  1  single clock, all logic rising-edge
- resetn  in  1  asynchronous active-low reset
- pkt_valid  in  1  data_in holds a packet word
- data_in  in  DATA_WIDTH  packet word
- read_enb  in  NUM_PORTS  per-port pop request
- data_out  out  NUM_PORTS*DATA_WIDTH  port i word at [i*DATA_WIDTH +: DATA_WIDTH]
- vld_out  out  NUM_PORTS  port FIFO non-empty
- soft_reset  out  NUM_PORTS  one-cycle pulse when port i is flushed by timeout
- busy  out  1  input word not accepted this cycle
- error  out  1  parity error on last packet
- drop  out  1  one-cycle pulse when an invalid-address header is accepted

Behaviour:
- Reset: all outputs 0; FIFOs empty; FSM in IDLE; timers, parity accumulator and length counter cleared. Reset mid-packet discards everything.
- Word acceptance: a word is accepted when pkt_valid=1 and busy=0. When pkt_valid=0 mid-packet, the FSM waits indefinitely with no timeout.
- Header fields: addr = data_in[ADDR_W-1:0]; len = data_in[DATA_WIDTH-1:ADDR_W], giving 0..2^(DATA_WIDTH-ADDR_W)-1 payload words.
- busy:
  - In IDLE: busy = pkt_valid & addr<NUM_PORTS & full[addr] (combinational).
  - In PAYLOAD/PARITY: busy = full[dest].
  - In DROP: busy = 0.
- FSM states and transitions:
  - IDLE, on accepted header:
    - addr<NUM_PORTS: write header to FIFO[addr], latch dest/len, parity acc = header; go to PAYLOAD, or to PARITY if len=0.
    - otherwise: pulse drop, go to DROP with count len+1.
  - PAYLOAD: each accepted word is written to FIFO[dest] and XORed into acc; count decrements. After the last payload word, go to PARITY.
  - PARITY: the accepted word is written to FIFO[dest]; compare with acc; go to IDLE.
  - DROP: accepted words are discarded; go to IDLE after len+1 words.
- error: registered, updates the cycle after the parity word is accepted (1 = mismatch). Holds until the next valid header is accepted, which clears it.
- Port FIFO:
  - Write and read in the same cycle are allowed when non-empty; a write to a full FIFO is prevented by busy.
  - Pointers wrap modulo FIFO_DEPTH; full/empty are exact (extra pointer bit).
  - vld_out[i] = ~empty[i].
- data_out[i]:
  - Registered; loaded with the head word the cycle after read_enb[i]=1 while non-empty.
  - Otherwise holds its value; a read on empty is ignored.
  - Driven to 0 on flush.
- Timeout:
  - Per-port counter increments while vld_out[i]=1 and read_enb[i]=0; clears on read or empty.
  - On reaching TIMEOUT: FIFO i is flushed (empty next cycle) and soft_reset[i] pulses for one cycle.
  - If dest is flushed mid-packet, the FSM moves to DROP for the remaining words.
- Simultaneous header and flush of the same addressed port: flush takes priority; the header is written into the emptied FIFO.

Optional Feature:
- Macro ROUTER_PKT_CNT_EN.
- When defined: adds output pkt_cnt (NUM_PORTS*16) with one 16-bit counter per port.
  - The counter increments when that port's parity word is written with no mismatch.
  - It wraps at 65535->0, resets to 0 and is not affected by soft reset.
- When undefined: the port and the counters are absent; behaviour is otherwise identical.

Test Plan:
- Defaults; header 8'h0D (addr1,len3), payload 11,22,33, parity 0D^11^22^33 -> FIFO1 holds 5 words, vld_out=3'b010, error=0; reading 5 cycles returns the words in order.
- Same packet with parity 8'h00 -> error=1 the cycle after parity is accepted; cleared when the next header is accepted.
- Header 8'h0B (addr3,len2) + 3 words -> drop pulses once, no FIFO written, busy=0 throughout, next packet to port 0 routes correctly.
- Header addr0,len=20 with read_enb=0 -> busy rises after 16 words are accepted; source holds; reading one word lowers busy for exactly one accepted word.
- Packet to port 2, no reads for 30 cycles -> soft_reset[2] pulses, vld_out[2]=0 the next cycle, data_out[2]=0.
- resetn low mid-payload -> all FIFOs empty, busy/error/vld_out=0; a new packet after release routes normally.
